// File: rtl/jt12_timers.sv
// jt12_timers: OPN Timer A/B with sample prescaler, status flags, IRQ and CSM overflow pulse
module jt12_timers #(
  parameter int SLOT_CNT = 24,
  parameter int A_W      = 10,
  parameter int B_W      = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clk_en,
  input  logic [A_W-1:0] value_A,
  input  logic [B_W-1:0] value_B,
  input  logic           load_A,
  input  logic           load_B,
  input  logic           flagen_A,
  input  logic           flagen_B,
  input  logic           clr_flag_A,
  input  logic           clr_flag_B,
  output logic           flag_A,
  output logic           flag_B,
  output logic           ovf_A,
  output logic           irq_n
);
  logic [4:0]     slot_cnt;
  logic [3:0]     pre_b;
  logic           load_a_q, load_b_q;
  logic [A_W-1:0] cnt_a;
  logic [B_W-1:0] cnt_b;
  logic           tick_smp, tick_b, ld_a, ld_b, ovf_a_now, ovf_b_now;
  assign tick_smp  = clk_en && slot_cnt == 5'(SLOT_CNT - 1);
  assign tick_b    = tick_smp && pre_b == 4'hf;
  assign ld_a      = load_A & ~load_a_q;
  assign ld_b      = load_B & ~load_b_q;
  // a load edge takes priority over a coincident tick, so it can never overflow that cycle
  assign ovf_a_now = tick_smp & load_A & ~ld_a & (&cnt_a);
  assign ovf_b_now = tick_b & load_B & ~ld_b & (&cnt_b);
  assign irq_n     = ~(flag_A | flag_B);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      slot_cnt <= '0;
      pre_b    <= '0;
      load_a_q <= 1'b0;
      load_b_q <= 1'b0;
      cnt_a    <= '0;
      cnt_b    <= '0;
      ovf_A    <= 1'b0;
      flag_A   <= 1'b0;
      flag_B   <= 1'b0;
    end else begin
      if (clk_en) slot_cnt <= slot_cnt == 5'(SLOT_CNT - 1) ? '0 : slot_cnt + 5'd1;
      if (tick_smp) pre_b <= pre_b + 4'd1;
      load_a_q <= load_A;
      load_b_q <= load_B;
      if (ld_a || ovf_a_now) cnt_a <= value_A;
      else if (tick_smp && load_A) cnt_a <= cnt_a + A_W'(1);
      if (ld_b || ovf_b_now) cnt_b <= value_B;
      else if (tick_b && load_B) cnt_b <= cnt_b + B_W'(1);
      ovf_A  <= ovf_a_now;
      flag_A <= (ovf_a_now & flagen_A) | (flag_A & ~clr_flag_A);
      flag_B <= (ovf_b_now & flagen_B) | (flag_B & ~clr_flag_B);
    end
endmodule
